// File: rtl/fault_campaign_ctrl_pkg.sv
// fault_camp_pkg: shared types and defaults for the fault campaign controller.
//   state_t  : controller FSM states
//   cls_t    : injection outcome class (masked / detected / silent corruption)
//   classify : maps checker flag and golden-mismatch flag to a class
package fault_camp_pkg;

   localparam int NG_DEF     = 128;
   localparam int SETTLE_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INJECT = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_CLEAR  = 3'd3,
      ST_FIN    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CLS_MSK = 2'b00,
      CLS_DET = 2'b01,
      CLS_SDC = 2'b10
   } cls_t;

   // The residue checker flag dominates: a detected fault is detected even
   // if the result also differs from golden.
   function automatic cls_t classify(input logic eq_err, input logic res_err);
      if (eq_err)       return CLS_DET;
      else if (res_err) return CLS_SDC;
      else              return CLS_MSK;
   endfunction

endpackage

// File: rtl/fault_campaign_ctrl_if.sv
// fault_campaign_ctrl_if: host / fault-network signals of the campaign controller.
//   master : host side (drives start/abort/range and the DUT flags eq_err/res_err)
//   slave  : controller side (drives fault_en_bus, fault_val, busy, done, counters)
// With FAULT_CAMP_LOG_EN defined, a per-injection log record
// (log_vld/log_gid/log_val/log_cls) is added.
interface fault_campaign_ctrl_if #(
   parameter int NG    = 128,
   parameter int GID_W = 7,
   parameter int CNT_W = 9
);
   logic             start;
   logic             abort;
   logic [GID_W-1:0] gid_first;
   logic [GID_W-1:0] gid_last;
   logic             eq_err;
   logic             res_err;
   logic [NG-1:0]    fault_en_bus;
   logic             fault_val;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] det_cnt;
   logic [CNT_W-1:0] sdc_cnt;
   logic [CNT_W-1:0] msk_cnt;
`ifdef FAULT_CAMP_LOG_EN
   logic                 log_vld;
   logic [GID_W-1:0]     log_gid;
   logic                 log_val;
   fault_camp_pkg::cls_t log_cls;

   modport master (
      output start, abort, gid_first, gid_last, eq_err, res_err,
      input  fault_en_bus, fault_val, busy, done, det_cnt, sdc_cnt, msk_cnt,
      input  log_vld, log_gid, log_val, log_cls
   );
   modport slave (
      input  start, abort, gid_first, gid_last, eq_err, res_err,
      output fault_en_bus, fault_val, busy, done, det_cnt, sdc_cnt, msk_cnt,
      output log_vld, log_gid, log_val, log_cls
   );
`else
   modport master (
      output start, abort, gid_first, gid_last, eq_err, res_err,
      input  fault_en_bus, fault_val, busy, done, det_cnt, sdc_cnt, msk_cnt
   );
   modport slave (
      input  start, abort, gid_first, gid_last, eq_err, res_err,
      output fault_en_bus, fault_val, busy, done, det_cnt, sdc_cnt, msk_cnt
   );
`endif
endinterface

// File: rtl/fault_campaign_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : clear to zero (wins over inc_i)
//   inc_i      : increment, sticks at all-ones
//   cnt_o      : count value
module sat_counter #(
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                      cnt_d = '0;
      else if (inc_i && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: single-fault injection campaign sequencer.
// Walks gate IDs gid_first..gid_last (last clamped to NG-1), injecting
// stuck-at-0 then stuck-at-1 on each via a one-hot fault_en_bus, samples the
// checker / golden flags and counts detected, silent and masked outcomes.
//   clk, rst_n : clock, async active-low reset
//   fc         : fault_campaign_ctrl_if.slave (host handshake, fault bus, counters)
// Optional macro FAULT_CAMP_LOG_EN adds a per-injection log record on fc.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start, bus zero
// ST_INJECT | bus = 1 << gid, settle down-counter running
// ST_SAMPLE | bus still driven, flags classified and counted
// ST_CLEAR  | bus zero for one cycle, advance polarity / gate
// ST_FIN    | done pulse, back to idle
module fault_campaign_ctrl
   import fault_camp_pkg::*;
#(
   parameter int NG         = NG_DEF,
   parameter int GID_W      = 7,
   parameter int SETTLE_CYC = SETTLE_DEF,
   parameter int CNT_W      = 9
) (
   input logic                  clk,
   input logic                  rst_n,
   fault_campaign_ctrl_if.slave fc
);
   localparam int             SET_W    = $clog2(SETTLE_CYC + 1);
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

   state_t           state_q, state_d;
   logic [GID_W-1:0] gid_q, gid_d;
   logic [GID_W-1:0] last_q, last_d;
   logic             val_q, val_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic             clr;
   logic             smp;
   cls_t             cls;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         gid_q    <= '0;
         last_q   <= '0;
         val_q    <= 1'b0;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         gid_q    <= gid_d;
         last_q   <= last_d;
         val_q    <= val_d;
         settle_q <= settle_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gid_d    = gid_q;
      last_d   = last_q;
      val_d    = val_q;
      settle_d = settle_q;
      clr      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fc.start) begin
               clr      = 1'b1;
               gid_d    = fc.gid_first;
               val_d    = 1'b0;
               settle_d = SET_LOAD;
               last_d   = (int'(fc.gid_last) >= NG) ? GID_W'(NG - 1) : fc.gid_last;
               state_d  = (fc.gid_first > last_d) ? ST_FIN : ST_INJECT;
            end
         end
         ST_INJECT: begin
            if (settle_q == '0) state_d = ST_SAMPLE;
            else                settle_d = settle_q - 1'b1;
         end
         ST_SAMPLE: state_d = ST_CLEAR;
         ST_CLEAR: begin
            settle_d = SET_LOAD;
            if (!val_q) begin
               val_d   = 1'b1;
               state_d = ST_INJECT;
            end else if (gid_q == last_q) begin
               state_d = ST_FIN;
            end else begin
               gid_d   = gid_q + 1'b1;
               val_d   = 1'b0;
               state_d = ST_INJECT;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Abort drops everything except the counters, which keep partial results.
      if (state_q != ST_IDLE && fc.abort) state_d = ST_IDLE;
   end

   // Bus is decoded straight from the state register so that the async reset
   // clears it in the same cycle.
   assign fc.fault_en_bus = (state_q == ST_INJECT || state_q == ST_SAMPLE)
                            ? (NG'(1) << gid_q) : '0;
   assign fc.fault_val    = val_q;
   assign fc.busy         = (state_q == ST_INJECT) || (state_q == ST_SAMPLE) ||
                            (state_q == ST_CLEAR);
   assign fc.done         = (state_q == ST_FIN);

   assign smp = (state_q == ST_SAMPLE);
   assign cls = classify(fc.eq_err, fc.res_err);

   sat_counter #(.CNT_W(CNT_W)) u_det (
      .clk(clk), .rst_n(rst_n), .clr_i(clr),
      .inc_i(smp && cls == CLS_DET), .cnt_o(fc.det_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_sdc (
      .clk(clk), .rst_n(rst_n), .clr_i(clr),
      .inc_i(smp && cls == CLS_SDC), .cnt_o(fc.sdc_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_msk (
      .clk(clk), .rst_n(rst_n), .clr_i(clr),
      .inc_i(smp && cls == CLS_MSK), .cnt_o(fc.msk_cnt));

`ifdef FAULT_CAMP_LOG_EN
   logic             log_vld_q;
   logic [GID_W-1:0] log_gid_q;
   logic             log_val_q;
   cls_t             log_cls_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         log_vld_q <= 1'b0;
         log_gid_q <= '0;
         log_val_q <= 1'b0;
         log_cls_q <= CLS_MSK;
      end else begin
         log_vld_q <= smp;
         if (smp) begin
            log_gid_q <= gid_q;
            log_val_q <= val_q;
            log_cls_q <= cls;
         end
      end
   end

   assign fc.log_vld = log_vld_q;
   assign fc.log_gid = log_gid_q;
   assign fc.log_val = log_val_q;
   assign fc.log_cls = log_cls_q;
`endif
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Scoreboard bench for fault_campaign_ctrl (NG=8, GID_W=8, SETTLE_CYC=2, CNT_W=4).
// Stimulus pushes expected injections and done records; a negedge monitor
// pops and compares whenever the bus starts an injection or done pulses.
module tb_fault_campaign_ctrl;
   localparam int NG = 8;
   localparam int GID_W = 8;
   localparam int SETTLE = 2;
   localparam int CNT_W = 4;

   typedef struct {int bus; int val; int len;} inj_t;
   typedef struct {int cyc; int det; int sdc; int msk;} done_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   mode = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   inv_bad = 0;
   int   run = 0;
   int   prev_bus = 0;
   inj_t  cur;
   inj_t  inj_q[$];
   done_t done_q[$];

   fault_campaign_ctrl_if #(.NG(NG), .GID_W(GID_W), .CNT_W(CNT_W)) ifc ();

   fault_campaign_ctrl #(.NG(NG), .GID_W(GID_W), .SETTLE_CYC(SETTLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .fc(ifc.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Model of the fault-instrumented datapath's flags.
   always_comb begin
      ifc.eq_err  = 1'b0;
      ifc.res_err = 1'b0;
      case (mode)
         0: ifc.eq_err = 1'b1;
         1: ifc.res_err = ifc.fault_val;
         2: begin
            ifc.eq_err  = |(ifc.fault_en_bus & 8'hA0);
            ifc.res_err = ifc.fault_val;
         end
         default: ;
      endcase
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_evt(input string name, input int act);
      n_chk++;
      $display("FAIL %s: got %0d expected none (cycle %0d)", name, act, cyc);
   endtask

   always @(negedge clk) begin
      int b;
      b = int'(ifc.fault_en_bus);
      if (b != 0) begin
         if (prev_bus == 0) begin
            if (inj_q.size() == 0) begin
               fail_evt("inj_unexpected", b);
               cur = '{b, 0, 0};
            end else begin
               cur = inj_q.pop_front();
               chk("inj_bus", b, cur.bus);
               chk("inj_val", int'(ifc.fault_val), cur.val);
            end
            run = 1;
         end else begin
            if (b != prev_bus) inv_bad++;
            run++;
         end
      end else if (prev_bus != 0) begin
         chk("inj_len", run, cur.len);
      end
      if ($countones(ifc.fault_en_bus) > 1) inv_bad++;
      if (b != 0 && !ifc.busy) inv_bad++;
      if (ifc.done) begin
         if (done_q.size() == 0) fail_evt("done_unexpected", cyc);
         else begin
            done_t d;
            d = done_q.pop_front();
            chk("done_cyc", cyc, d.cyc);
            chk("det_cnt", int'(ifc.det_cnt), d.det);
            chk("sdc_cnt", int'(ifc.sdc_cnt), d.sdc);
            chk("msk_cnt", int'(ifc.msk_cnt), d.msk);
            chk("busy_at_done", int'(ifc.busy), 0);
         end
      end
      prev_bus = b;
   end

   task automatic push_range(input int first, input int last);
      for (int g = first; g <= last; g++)
         for (int v = 0; v < 2; v++) inj_q.push_back('{1 << g, v, SETTLE + 1});
   endtask

   // Pushes the done record (if any) before start is driven so an
   // immediate done cannot race the push.
   task automatic launch(input int first, input int last, input int m,
                         input bit exp_done, input int n, input int det,
                         input int sdc, input int msk, output int sc);
      @(negedge clk);
      sc = cyc;
      if (exp_done) done_q.push_back('{sc + 2 * n * (SETTLE + 2) + 1, det, sdc, msk});
      mode = m;
      ifc.gid_first = GID_W'(first);
      ifc.gid_last  = GID_W'(last);
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int n = 0; n < budget && (done_q.size() != 0 || inj_q.size() != 0); n++)
         @(negedge clk);
      chk("sb_drain", done_q.size() + inj_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      ifc.gid_first = '0;
      ifc.gid_last = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_bus", int'(ifc.fault_en_bus), 0);
      chk("rst_busy", int'(ifc.busy), 0);
      chk("rst_done", int'(ifc.done), 0);
      chk("rst_val", int'(ifc.fault_val), 0);
      chk("rst_cnts", int'(ifc.det_cnt) + int'(ifc.sdc_cnt) + int'(ifc.msk_cnt), 0);

      // Range 2..3, all detected; a second start mid-campaign must be ignored.
      push_range(2, 3);
      launch(2, 3, 0, 1, 2, 4, 0, 0, sc);
      while (cyc < sc + 6) @(negedge clk);
      ifc.gid_first = 8'd0;
      ifc.gid_last = 8'd0;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      drain(100);

      // Single gate, silent corruption only on stuck-at-1.
      push_range(0, 0);
      launch(0, 0, 1, 1, 1, 0, 1, 1, sc);
      drain(100);

      // Empty range: immediate done, counters cleared, no injection.
      launch(5, 3, 1, 1, 0, 0, 0, 0, sc);
      drain(100);

      // gid_last clamped to 7: gates 5,7 detected, 4,6 sdc on sa1 / masked on sa0.
      push_range(4, 7);
      launch(4, 200, 2, 1, 4, 4, 2, 2, sc);
      drain(200);

      // Full range, 16 detections saturate the 4-bit counter at 15.
      push_range(0, 7);
      launch(0, 7, 0, 1, 8, 15, 0, 0, sc);
      drain(200);

      // Abort during the second INJECT.
      inj_q.push_back('{2, 0, SETTLE + 1});
      inj_q.push_back('{2, 1, 1});
      launch(1, 2, 0, 0, 0, 0, 0, 0, sc);
      while (cyc < sc + 5) @(negedge clk);
      ifc.abort = 1'b1;
      @(negedge clk);
      ifc.abort = 1'b0;
      chk("abort_bus", int'(ifc.fault_en_bus), 0);
      chk("abort_busy", int'(ifc.busy), 0);
      chk("abort_det", int'(ifc.det_cnt), 1);
      repeat (12) @(negedge clk);
      drain(50);

      // Reset during the SAMPLE of the second injection.
      inj_q.push_back('{8, 0, SETTLE + 1});
      inj_q.push_back('{8, 1, SETTLE + 1});
      launch(3, 4, 0, 0, 0, 0, 0, 0, sc);
      while (cyc < sc + 7) @(negedge clk);
      chk("pre_rst_det", int'(ifc.det_cnt), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_bus", int'(ifc.fault_en_bus), 0);
      chk("async_rst_busy", int'(ifc.busy), 0);
      chk("async_rst_cnts", int'(ifc.det_cnt) + int'(ifc.sdc_cnt) + int'(ifc.msk_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Normal campaign after reset.
      push_range(6, 6);
      launch(6, 6, 1, 1, 1, 0, 1, 1, sc);
      drain(100);

      chk("invariant_violations", inv_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
